cargador_de_programa: RTL and testbench

Program loader that fills the 9-bit instruction memory read by the CPU's instruction decoder. It receives a framed byte stream from the host link (UART receiver byte strobe) and reassembles 9-bit instruction words, `opcode[2:0]`, `RX[5:3]`, `field[8:6]`. It writes the words sequentially into program RAM and holds the CPU stalled while a load is in progress. It sits between the host-link receiver and the program RAM write port.

---
 rtl/cargador_de_programa.sv | 207 ++++++++++++++++++++
 tb/tb_cargador_de_programa.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cargador_de_programa.sv
// Purpose : program loader; reassembles 9-bit instruction words from a framed host byte stream into program RAM.
// Latency : header strobe -> busy/cpu_hold next cycle; HI strobe -> mem_we next cycle; CHK strobe -> done next cycle.
// Backpressure: none; one byte per cycle (back-to-back strobes) is always accepted, bytes in FIN are dropped.
//
// Optional feature macro: CARGADOR_CHECKSUM_EN (defined = trailing XOR checksum byte required).
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_byte_in/_valid    received byte and its one-cycle strobe
//   o_mem_we/_addr/_data program RAM write port (registered, one-cycle we pulse)
//   o_cpu_hold          stalls the CPU while a load is in progress or has failed
//   o_busy              frame in progress
//   o_done              one-cycle pulse on successful frame completion
//   o_error             sticky frame error, cleared by the next header byte
module cargador_de_programa #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_byte_in,
    input  logic              i_byte_valid,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [8:0]        o_mem_data,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [7:0]  HEADER    = 8'hA5;
    // Largest legal instruction count, kept wide enough to hold 2^ADDR_W.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

`ifdef CARGADOR_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_LO, S_HI, S_CHK, S_FIN, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_LO, S_HI, S_FIN, S_ERR
    } state_t;
`endif

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [7:0]        r_lo;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [8:0]        r_mem_data;
    logic              r_cpu_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
`ifdef CARGADOR_CHECKSUM_EN
    logic [7:0]        r_chk;
`endif

    logic w_hdr;
    logic w_count_bad;
    logic w_hi_bad;

    assign w_hdr       = i_byte_valid && (i_byte_in == HEADER);
    assign w_count_bad = (i_byte_in == 8'd0) || ({25'd0, i_byte_in} > MAX_WORDS);
    assign w_hi_bad    = (i_byte_in[7:1] != 7'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_lo       <= 8'd0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= 9'd0;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
            r_chk      <= 8'd0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;

            // Address advances during the write cycle so the next address
            // is visible one cycle after the write pulse.
            if (r_mem_we) begin
                r_mem_addr <= r_mem_addr + 1'b1;
            end

            case (r_state)
                // ERR re-arms on a header exactly like IDLE; hold stays up
                // in ERR until that happens because RAM contents are partial.
                S_IDLE, S_ERR: begin
                    if (w_hdr) begin
                        r_state    <= S_COUNT;
                        r_busy     <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_error    <= 1'b0;
                        r_mem_addr <= '0;
`ifdef CARGADOR_CHECKSUM_EN
                        r_chk      <= 8'd0;
`endif
                    end
                end

                S_COUNT: begin
                    if (i_byte_valid) begin
                        if (w_count_bad) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_LO;
                            r_cnt   <= i_byte_in;
`ifdef CARGADOR_CHECKSUM_EN
                            r_chk   <= r_chk ^ i_byte_in;
`endif
                        end
                    end
                end

                S_LO: begin
                    if (i_byte_valid) begin
                        r_state <= S_HI;
                        r_lo    <= i_byte_in;
`ifdef CARGADOR_CHECKSUM_EN
                        r_chk   <= r_chk ^ i_byte_in;
`endif
                    end
                end

                S_HI: begin
                    if (i_byte_valid) begin
                        if (w_hi_bad) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_mem_we   <= 1'b1;
                            r_mem_data <= {i_byte_in[0], r_lo};
                            r_cnt      <= r_cnt - 8'd1;
`ifdef CARGADOR_CHECKSUM_EN
                            r_chk      <= r_chk ^ i_byte_in;
`endif
                            if (r_cnt == 8'd1) begin
`ifdef CARGADOR_CHECKSUM_EN
                                r_state <= S_CHK;
`else
                                r_state <= S_FIN;
`endif
                            end else begin
                                r_state <= S_LO;
                            end
                        end
                    end
                end

`ifdef CARGADOR_CHECKSUM_EN
                S_CHK: begin
                    if (i_byte_valid) begin
                        if (i_byte_in == r_chk) begin
                            // Release the CPU together with done; FIN only
                            // swallows one cycle of traffic afterwards.
                            r_state    <= S_FIN;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                S_FIN: begin
                    r_state <= S_IDLE;
                end
`else
                // Without a checksum FIN is entered straight from the last
                // HI byte, so done lands one cycle after the final write.
                S_FIN: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= 1'b0;
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_we   = r_mem_we;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_data = r_mem_data;
    assign o_cpu_hold = r_cpu_hold;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_error    = r_error;

endmodule

// File: tb/tb_cargador_de_programa.sv
module tb_cargador_de_programa;

    localparam int AW = 4;
    localparam int MAXN = 1 << AW;

    localparam int K_GOOD   = 0;
    localparam int K_BADHI  = 1;
    localparam int K_BADCHK = 2;
    localparam int K_CNT    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [8:0]    mem_data;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    cargador_de_programa #(.ADDR_W(AW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_byte_in    (byte_in),
        .i_byte_valid (byte_valid),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_data),
        .o_cpu_hold   (cpu_hold),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  done_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every write the DUT presents is matched against the
    // expected-write queue; done pulses are counted for frame-level checks.
    initial begin : monitor
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), e.addr);
                    check("wr_data", 32'(mem_data), e.data);
                end
            end
            if (done === 1'b1) done_seen++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one byte for exactly one rising edge; returns 1 time unit after
    // that edge so the caller sees the outputs of the following cycle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame; the expected RAM writes and end-of-frame status are
    // derived from what kind of frame is being built, not from the bytes.
    task automatic run_frame(input logic [8:0] words[$], input int cnt, input int kind,
                             input int bad_pos, input bit gaps);
        logic [7:0] lo, hi, x;
        int d0;
        bit good;
        d0   = done_seen;
        good = (kind == K_GOOD);
        x    = cnt[7:0];
        send_byte(8'hA5);
        check("hdr_busy", 32'(busy), 1);
        check("hdr_hold", 32'(cpu_hold), 1);
        send_byte(cnt[7:0]);
        if (kind == K_CNT) begin
            check("cnt_error", 32'(error), 1);
        end else begin
            for (int i = 0; i < words.size(); i++) begin
                lo = words[i][7:0];
                hi = {7'd0, words[i][8]};
                if (kind == K_BADHI && i == bad_pos)
                    hi[7:1] = 7'($urandom_range(1, 127));
                else
                    exp_q.push_back('{i, int'(words[i])});
                if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_byte(lo);
                x ^= lo;
                if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_byte(hi);
                x ^= hi;
                if (kind == K_BADHI && i == bad_pos) begin
                    check("badhi_error", 32'(error), 1);
                    check("badhi_no_we", 32'(mem_we), 0);
                    break;
                end
`ifndef CARGADOR_CHECKSUM_EN
                if (i == words.size() - 1) begin
                    check("last_we_t1", 32'(mem_we), 1);
                    idle(1);
                    check("done_t2", 32'(done), 1);
                    check("hold_rel_t2", 32'(cpu_hold), 0);
                end
`endif
            end
`ifdef CARGADOR_CHECKSUM_EN
            if (kind == K_GOOD) begin
                send_byte(x);
                check("done_t1", 32'(done), 1);
                check("hold_rel_t1", 32'(cpu_hold), 0);
            end else if (kind == K_BADCHK) begin
                send_byte(x ^ 8'($urandom_range(1, 255)));
                check("badchk_error", 32'(error), 1);
            end
`endif
        end
        idle(4);
        check("frame_done_cnt", done_seen - d0, good ? 1 : 0);
        check("frame_error", 32'(error), good ? 0 : 1);
        check("frame_busy", 32'(busy), 0);
        check("frame_hold", 32'(cpu_hold), good ? 0 : 1);
        check("frame_pending_writes", exp_q.size(), 0);
    endtask

    task automatic rand_words(input int n, output logic [8:0] w[$]);
        w = {};
        for (int i = 0; i < n; i++) w.push_back(9'($urandom));
    endtask

    initial begin : stim
        logic [8:0] w[$];
        int n, kind;
        rst        = 1'b1;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        idle(3);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_data", 32'(mem_data), 0);
        check("rst_cpu_hold", 32'(cpu_hold), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Reference frame: 0x028 then 0x105.
        w = {9'h028, 9'h105};
        run_frame(w, 2, K_GOOD, 0, 1'b0);
`ifdef CARGADOR_CHECKSUM_EN
        run_frame(w, 2, K_BADCHK, 0, 1'b0);
`endif
        // Bad HI on the second pair, then a fresh frame restarts at address 0.
        run_frame(w, 2, K_BADHI, 1, 1'b0);
        run_frame(w, 2, K_GOOD, 0, 1'b0);
        // Count boundaries.
        run_frame(w, 0, K_CNT, 0, 1'b0);
        run_frame(w, MAXN + 1, K_CNT, 0, 1'b0);
        rand_words(MAXN, w);
        run_frame(w, MAXN, K_GOOD, 0, 1'b0);

        // Junk bytes in IDLE are ignored.
        send_byte(8'h11);
        check("junk_busy", 32'(busy), 0);
        check("junk_hold", 32'(cpu_hold), 0);
        send_byte(8'h22);
        check("junk_busy2", 32'(busy), 0);
        check("junk_error", 32'(error), 0);
        idle(3);
        check("junk_no_writes", exp_q.size(), 0);

        // Reset after 3 of 5 instructions written.
        rand_words(5, w);
        send_byte(8'hA5);
        send_byte(8'd5);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{i, int'(w[i])});
            send_byte(w[i][7:0]);
            send_byte({7'd0, w[i][8]});
        end
        rst = 1'b1;
        send_byte(w[3][7:0]);
        check("midrst_mem_we", 32'(mem_we), 0);
        check("midrst_mem_addr", 32'(mem_addr), 0);
        check("midrst_mem_data", 32'(mem_data), 0);
        check("midrst_cpu_hold", 32'(cpu_hold), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_error", 32'(error), 0);
        send_byte({7'd0, w[3][8]});
        check("midrst_no_we", 32'(mem_we), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("midrst_pending", exp_q.size(), 0);
        rand_words(3, w);
        run_frame(w, 3, K_GOOD, 0, 1'b0);

        // Randomized frames, mixing back-to-back and gapped byte streams.
        for (int f = 0; f < 24; f++) begin
            kind = $urandom_range(0, 3);
`ifndef CARGADOR_CHECKSUM_EN
            if (kind == K_BADCHK) kind = K_GOOD;
`endif
            n = $urandom_range(1, MAXN);
            rand_words(n, w);
            if (kind == K_CNT)
                run_frame(w, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXN + 1, 255),
                          K_CNT, 0, 1'b0);
            else
                run_frame(w, n, kind, $urandom_range(0, n - 1), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
